// File: rtl/sync_receiver.sv
// sync_receiver: recovers the 16-cycle SYNC square wave on the receiving side of the link.
// It triple-flops the pin and locks a local 16-phase counter to the SYNC rising edge.
// It reports lock and flags/counts edges that are missing or in the wrong place.
// Build option: define SYNC_RX_ERRCNT_EN to include the saturating error counter and clear_i.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_SEARCH  | no phase reference; waiting for a rising edge to anchor on
// S_ACQUIRE | anchored; counting consecutive correctly placed edges
// S_LOCKED  | phase trusted; bad events pulse err_o and may drop lock
module sync_receiver #(
  parameter logic [3:0] PHASE_OFFSET = 4'd0,
  parameter int         LOCK_EDGES   = 4,
  parameter int         MISS_LIMIT   = 2
) (
  input  logic       sysclk_i,
  input  logic       reset,
  input  logic       SYNC,
  input  logic       clear_i,
  output logic [3:0] phase_o,
  output logic       locked_o,
  output logic       err_o,
  output logic [7:0] err_count_o
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  // Reload lands one past the offset so the detect cycle itself reads PHASE_OFFSET.
  localparam logic [3:0] LP_RELOAD  = PHASE_OFFSET + 4'd1;
  localparam logic [3:0] LP_FALL_PT = PHASE_OFFSET + 4'd8;
  localparam logic [3:0] LP_LOCK    = 4'(LOCK_EDGES);
  localparam logic [2:0] LP_MISS    = 3'(MISS_LIMIT);

  (* IOB = "TRUE", KEEP = "TRUE" *) logic r_q1;
  logic       r_q2;
  logic       r_q3;
  state_t     r_state;
  logic [3:0] r_p;
  logic [3:0] r_good;
  logic [2:0] r_bad;
  logic       r_err;
  logic       r_locked;

  state_t     w_state_nxt;
  logic [3:0] w_p_nxt;
  logic [3:0] w_good_nxt;
  logic [2:0] w_bad_nxt;
  logic       w_err_nxt;

  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_at_rise;
  logic w_at_fall;
  logic w_good;
  logic w_bad_event;

  assign w_rise    = r_q2 & ~r_q3;
  assign w_fall    = ~r_q2 & r_q3;
  assign w_edge    = w_rise | w_fall;
  assign w_at_rise = (r_p == PHASE_OFFSET);
  assign w_at_fall = (r_p == LP_FALL_PT);
  assign w_good    = (w_at_rise & w_rise) | (w_at_fall & w_fall);
  // A stray edge and a missed point are mutually exclusive, so at most one bad event per cycle.
  assign w_bad_event = (w_edge & ~w_at_rise & ~w_at_fall)
                     | (w_at_rise & ~w_rise)
                     | (w_at_fall & ~w_fall);

  // Pin capture chain; q1 is the pad-side flop.
  always_ff @(posedge sysclk_i or posedge reset) begin
    if (reset) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
      r_q3 <= 1'b0;
    end else begin
      r_q1 <= SYNC;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
    end
  end

  // State register plus phase counter, edge counters and registered outputs.
  always_ff @(posedge sysclk_i or posedge reset) begin
    if (reset) begin
      r_state  <= S_SEARCH;
      r_p      <= 4'd0;
      r_good   <= 4'd0;
      r_bad    <= 3'd0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_p      <= w_p_nxt;
      r_good   <= w_good_nxt;
      r_bad    <= w_bad_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
    end
  end

  // Next-state, phase reload and bad-event decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p + 4'd1;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_rise) begin
          w_p_nxt     = LP_RELOAD;
          w_good_nxt  = 4'd1;
          w_state_nxt = (LP_LOCK == 4'd1) ? S_LOCKED : S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (w_good) begin
          w_good_nxt = r_good + 4'd1;
          if (w_good_nxt == LP_LOCK) begin
            w_state_nxt = S_LOCKED;
          end
        end else if (w_edge) begin
          // A misplaced rise is immediately taken as a fresh anchor.
          if (w_rise) begin
            w_p_nxt     = LP_RELOAD;
            w_good_nxt  = 4'd1;
            w_state_nxt = (LP_LOCK == 4'd1) ? S_LOCKED : S_ACQUIRE;
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end else if (w_at_rise | w_at_fall) begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (w_bad_event) begin
          w_err_nxt = 1'b1;
          w_bad_nxt = r_bad + 3'd1;
          if (w_bad_nxt == LP_MISS) begin
            w_state_nxt = S_SEARCH;
            w_bad_nxt   = 3'd0;
          end
        end else if (w_good) begin
          w_bad_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt = S_SEARCH;
      end
    endcase
  end

  assign phase_o  = r_p;
  assign locked_o = r_locked;
  assign err_o    = r_err;

`ifdef SYNC_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating bad-event counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge sysclk_i or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (clear_i) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count_o = r_err_cnt;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_i;
  assign err_count_o    = 8'd0;
`endif

endmodule

// File: tb/tb_sync_receiver.sv
// Bench for sync_receiver: directed SYNC waveforms, a timebase-style reference model
// checked every cycle, and literal expectations for lock latency, error spacing and reset.
module tb_sync_receiver;

  localparam int OFF = 0;
  localparam int LE  = 4;
  localparam int ML  = 2;
`ifdef SYNC_RX_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int M_SRCH = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic       sysclk_i;
  logic       reset;
  logic       SYNC;
  logic       clear_i;
  logic [3:0] phase_o;
  logic       locked_o;
  logic       err_o;
  logic [7:0] err_count_o;

  sync_receiver dut (
    .sysclk_i    (sysclk_i),
    .reset       (reset),
    .SYNC        (SYNC),
    .clear_i     (clear_i),
    .phase_o     (phase_o),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_count_o (err_count_o)
  );

  initial sysclk_i = 1'b0;
  always #4 sysclk_i = ~sysclk_i;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic int pmod(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  always @(posedge sysclk_i) cyc++;

  // Reference model: phase is time since the last anchor; edges are pin samples two clocks old.
  int m_c, m_base, m_mode, m_good, m_bad, m_cnt, m_ph;
  bit m_err, h0, h1, h2;
  bit m_rs, m_fl, m_ed, m_atr, m_atf, m_gd, m_bd;

  always @(posedge sysclk_i or posedge reset) begin
    if (reset) begin
      m_c = 0; m_base = 0; m_mode = M_SRCH; m_good = 0; m_bad = 0; m_cnt = 0;
      m_err = 0; h0 = 0; h1 = 0; h2 = 0;
    end else begin
      m_rs  = h1 && !h2;
      m_fl  = !h1 && h2;
      m_ed  = m_rs || m_fl;
      m_ph  = pmod(m_c - m_base);
      m_atr = (m_ph == OFF);
      m_atf = (m_ph == (OFF + 8) % 16);
      m_gd  = (m_atr && m_rs) || (m_atf && m_fl);
      m_err = 0;
      if (m_mode == M_SRCH) begin
        if (m_rs) begin
          m_base = m_c - OFF; m_good = 1; m_mode = (LE == 1) ? M_LOCK : M_ACQ;
        end
      end else if (m_mode == M_ACQ) begin
        if (m_gd) begin
          m_good++;
          if (m_good >= LE) m_mode = M_LOCK;
        end else if (m_rs) begin
          m_base = m_c - OFF; m_good = 1; m_mode = (LE == 1) ? M_LOCK : M_ACQ;
        end else if (m_fl || m_atr || m_atf) begin
          m_mode = M_SRCH;
        end
      end else begin
        m_bd = (m_ed && !m_atr && !m_atf) || (m_atr && !m_rs) || (m_atf && !m_fl);
        if (m_bd) begin
          m_err = 1;
          if (CNT_EN && m_cnt < 255) m_cnt++;
          m_bad++;
          if (m_bad >= ML) begin m_mode = M_SRCH; m_bad = 0; end
        end else if (m_gd) begin
          m_bad = 0;
        end
      end
      if (clear_i) m_cnt = 0;
      m_c++;
      h2 = h1; h1 = h0; h0 = SYNC;
    end
  end

  // Per-cycle comparison against the model, plus event bookkeeping for literal checks.
  int err_pulses = 0, last_err_cyc = 0, prev_err_cyc = 0;
  int lock_rise_cyc = 0, lock_fall_cyc = 0;
  bit prev_lk = 0;

  always @(negedge sysclk_i) begin
    check("phase", int'(phase_o), pmod(m_c - m_base));
    check("locked", int'(locked_o), (m_mode == M_LOCK) ? 1 : 0);
    check("err", int'(err_o), int'(m_err));
    check("err_count", int'(err_count_o), m_cnt);
    if (err_o) begin
      err_pulses++; prev_err_cyc = last_err_cyc; last_err_cyc = cyc;
    end
    if (locked_o && !prev_lk) lock_rise_cyc = cyc;
    if (!locked_o && prev_lk) lock_fall_cyc = cyc;
    prev_lk = locked_o;
  end

  task automatic hold(input logic lvl, input int n);
    SYNC = lvl;
    repeat (n) @(negedge sysclk_i);
  endtask

  // One clean period starting with a rise; optionally pin phase at both detect cycles.
  task automatic period(input bit chk);
    SYNC = 1'b1;
    repeat (2) @(negedge sysclk_i);
    if (chk) check("rise_detect_phase", int'(phase_o), OFF);
    repeat (6) @(negedge sysclk_i);
    SYNC = 1'b0;
    repeat (2) @(negedge sysclk_i);
    if (chk) check("fall_detect_phase", int'(phase_o), (OFF + 8) % 16);
    repeat (6) @(negedge sysclk_i);
  endtask

  int t0, p0;

  initial begin
    reset = 1'b1; SYNC = 1'b0; clear_i = 1'b0;
    repeat (3) @(negedge sysclk_i);
    check("rst_phase", int'(phase_o), 0);
    check("rst_locked", int'(locked_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_err_count", int'(err_count_o), 0);
    reset = 1'b0;

    // Clean wave from reset: lock at 4th good edge + 2, then ~1000 clean cycles.
    t0 = cyc; p0 = err_pulses;
    period(1'b0);
    repeat (63) period(1'b1);
    check("lock_latency", lock_rise_cyc - t0, 27);
    check("clean_locked", int'(locked_o), 1);
    check("clean_err_pulses", err_pulses - p0, 0);
    check("clean_err_count", int'(err_count_o), 0);

    // Falling transition suppressed: fall point and next rise point both missed.
    p0 = err_pulses;
    hold(1'b1, 24);
    hold(1'b0, 8);
    check("supp_err_pulses", err_pulses - p0, 2);
    check("supp_err_gap", last_err_cyc - prev_err_cyc, 8);
    check("supp_drop_with_err", lock_fall_cyc, last_err_cyc);
    check("supp_locked", int'(locked_o), 0);
    check("supp_err_count", int'(err_count_o), CNT_EN ? 2 : 0);
    period(1'b0); period(1'b1); period(1'b1);
    check("supp_relock", int'(locked_o), 1);

    // SYNC held low: two misses 8 cycles apart, lock drops with the second.
    p0 = err_pulses;
    hold(1'b0, 40);
    check("low_err_pulses", err_pulses - p0, 2);
    check("low_err_gap", last_err_cyc - prev_err_cyc, 8);
    check("low_drop_with_err", lock_fall_cyc, last_err_cyc);
    check("low_locked", int'(locked_o), 0);
    period(1'b0); period(1'b1); period(1'b1);
    check("low_relock", int'(locked_o), 1);

    // Wave shifted 3 cycles late: miss then stray edge, then relock on the new phase.
    p0 = err_pulses;
    hold(1'b1, 11);
    hold(1'b0, 8);
    check("shift_err_pulses", err_pulses - p0, 2);
    check("shift_err_gap", last_err_cyc - prev_err_cyc, 3);
    check("shift_locked", int'(locked_o), 0);
    period(1'b0); period(1'b1); period(1'b1);
    check("shift_relock", int'(locked_o), 1);

    // 300 bad events across repeated lock/unlock, with a clear landing on the last one.
    reset = 1'b1;
    repeat (2) @(negedge sysclk_i);
    reset = 1'b0;
    p0 = err_pulses;
    for (int i = 0; i < 149; i++) begin
      period(1'b0); period(1'b0);
      hold(1'b0, 24);
    end
    period(1'b0); period(1'b0);
    hold(1'b0, 10);
    check("sat_err_count", int'(err_count_o), CNT_EN ? 255 : 0);
    clear_i = 1'b1;
    @(negedge sysclk_i);
    clear_i = 1'b0;
    check("clear_wins", int'(err_count_o), 0);
    check("clear_err_pulse", int'(err_o), 1);
    hold(1'b0, 13);
    check("sat_err_pulses", err_pulses - p0, 300);

    // Asynchronous reset mid-lock, then reacquire.
    period(1'b0); period(1'b1); period(1'b1);
    check("pre_rst_locked", int'(locked_o), 1);
    SYNC = 1'b1;
    @(negedge sysclk_i);
    #2 reset = 1'b1;
    #1;
    check("arst_phase", int'(phase_o), 0);
    check("arst_locked", int'(locked_o), 0);
    check("arst_err", int'(err_o), 0);
    check("arst_err_count", int'(err_count_o), 0);
    @(negedge sysclk_i);
    @(negedge sysclk_i);
    reset = 1'b0;
    hold(1'b1, 4);
    hold(1'b0, 8);
    period(1'b0); period(1'b1); period(1'b1);
    check("arst_relock", int'(locked_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
